// File: rtl/iob_cache_clr_sp_ram_pkg.sv
// Shared definitions for the clearable single-port cache RAM.
package iob_cache_clr_sp_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } clr_state_t;

    function automatic int n_lanes(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

endpackage

// File: rtl/iob_cache_clr_sp_ram_clr_ctrl.sv
// Clear-sweep FSM, request acceptance, RAM port muxing and read-valid/output pipeline.
module iob_cache_clr_ctrl
    import iob_cache_clr_sp_ram_pkg::*;
#(
    parameter int               DATA_W  = 32,
    parameter int               ADDR_W  = 10,
    parameter int               LANE_W  = 8,
    parameter int               N_LANES = 4,
    parameter int               OUT_REG = 0,
    parameter logic [LANE_W-1:0] CLR_VAL = '0
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               clr_i,
    output logic               busy_o,
    input  logic               req_i,
    output logic               ready_o,
    input  logic [N_LANES-1:0] we_i,
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic [DATA_W-1:0]  data_i,
    output logic               rvalid_o,
    output logic [DATA_W-1:0]  data_o,
    output logic [N_LANES-1:0] ram_en_o,
    output logic [N_LANES-1:0] ram_we_o,
    output logic [ADDR_W-1:0]  ram_addr_o,
    output logic [DATA_W-1:0]  ram_d_o,
    input  logic [DATA_W-1:0]  ram_q_i
);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clearing;
    logic              acc;
    logic              rd_acc;
    logic              rvld_p0_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter is cleared while idle so every sweep starts from address 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        clearing = (state_q == ST_CLEAR);
        busy_o   = clearing;
        ready_o  = !clearing;
    end

    assign acc    = req_i && ready_o;
    assign rd_acc = acc && (we_i == '0);

    // Lanes not written by a partial write stay disabled so their read latch holds.
    always_comb begin
        for (int k = 0; k < N_LANES; k++) begin
            ram_we_o[k] = clearing || (acc && we_i[k]);
            ram_en_o[k] = clearing || rd_acc || (acc && we_i[k]);
        end
        ram_addr_o = clearing ? cnt_q : addr_i;
        ram_d_o    = clearing ? {N_LANES{CLR_VAL}} : data_i;
    end

    // Stage p0: RAM read data available
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rvld_p0_q <= 1'b0;
        end else begin
            rvld_p0_q <= rd_acc;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic              rvld_p1_q;
        logic [DATA_W-1:0] data_p1_q;

        // Stage p1: output register
        always_ff @(posedge clk_i or posedge arst_i) begin
            if (arst_i) begin
                rvld_p1_q <= 1'b0;
                data_p1_q <= '0;
            end else begin
                rvld_p1_q <= rvld_p0_q;
                if (rvld_p0_q) begin
                    data_p1_q <= ram_q_i;
                end
            end
        end

        assign rvalid_o = rvld_p1_q;
        assign data_o   = data_p1_q;
    end else begin : g_no_out_reg
        assign rvalid_o = rvld_p0_q;
        assign data_o   = ram_q_i;
    end

endmodule

// File: rtl/iob_ram_sp.sv
// Technology single-port RAM model: synchronous write, registered read that holds between reads.
module iob_ram_sp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] d_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= d_i;
            end else begin
                d_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/iob_cache_clr_sp_ram.sv
// Lane-write-enable single-port RAM with automatic clear sweep after reset and on request.
module iob_cache_clr_sp_ram
    import iob_cache_clr_sp_ram_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 10,
    parameter int                LANE_W  = 8,
    parameter int                OUT_REG = 0,
    parameter logic [LANE_W-1:0] CLR_VAL = '0
) (
    input  logic                                   clk_i,
    input  logic                                   arst_i,
    input  logic                                   clr_i,
    output logic                                   busy_o,
    input  logic                                   req_i,
    output logic                                   ready_o,
    input  logic [n_lanes(DATA_W, LANE_W)-1:0]     we_i,
    input  logic [ADDR_W-1:0]                      addr_i,
    input  logic [DATA_W-1:0]                      data_i,
    output logic                                   rvalid_o,
    output logic [DATA_W-1:0]                      data_o
);

    localparam int N_LANES = n_lanes(DATA_W, LANE_W);

    if (DATA_W % LANE_W != 0) begin : g_bad_lane_w
        $error("iob_cache_clr_sp_ram: DATA_W must be a multiple of LANE_W");
    end

    logic [N_LANES-1:0] ram_en;
    logic [N_LANES-1:0] ram_we;
    logic [ADDR_W-1:0]  ram_addr;
    logic [DATA_W-1:0]  ram_d;
    logic [DATA_W-1:0]  ram_q;

    iob_cache_clr_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LANE_W (LANE_W),
        .N_LANES(N_LANES),
        .OUT_REG(OUT_REG),
        .CLR_VAL(CLR_VAL)
    ) u_ctrl (
        .clk_i     (clk_i),
        .arst_i    (arst_i),
        .clr_i     (clr_i),
        .busy_o    (busy_o),
        .req_i     (req_i),
        .ready_o   (ready_o),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .rvalid_o  (rvalid_o),
        .data_o    (data_o),
        .ram_en_o  (ram_en),
        .ram_we_o  (ram_we),
        .ram_addr_o(ram_addr),
        .ram_d_o   (ram_d),
        .ram_q_i   (ram_q)
    );

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        iob_ram_sp #(
            .DATA_W(LANE_W),
            .ADDR_W(ADDR_W)
        ) u_ram (
            .clk_i (clk_i),
            .en_i  (ram_en[k]),
            .we_i  (ram_we[k]),
            .addr_i(ram_addr),
            .d_i   (ram_d[k*LANE_W +: LANE_W]),
            .d_o   (ram_q[k*LANE_W +: LANE_W])
        );
    end

endmodule

// File: tb/tb_iob_cache_clr_sp_ram.sv
// Random and directed bench for iob_cache_clr_sp_ram, checking both OUT_REG settings side by side.
module tb_iob_cache_clr_sp_ram;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int LW    = 8;
    localparam int NL    = DW / LW;
    localparam int DEPTH = 2**AW;

    logic          clk = 1'b0;
    logic          arst;
    logic          clr = 1'b0;
    logic          req = 1'b0;
    logic [NL-1:0] we = '0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;

    logic          busy0, ready0, rv0;
    logic [DW-1:0] q0;
    logic          busy1, ready1, rv1;
    logic [DW-1:0] q1;

    always #5 clk = ~clk;

    iob_cache_clr_sp_ram #(.DATA_W(DW), .ADDR_W(AW), .LANE_W(LW), .OUT_REG(0), .CLR_VAL(8'h00)) dut0 (
        .clk_i(clk), .arst_i(arst), .clr_i(clr), .busy_o(busy0), .req_i(req), .ready_o(ready0),
        .we_i(we), .addr_i(addr), .data_i(wdata), .rvalid_o(rv0), .data_o(q0)
    );

    iob_cache_clr_sp_ram #(.DATA_W(DW), .ADDR_W(AW), .LANE_W(LW), .OUT_REG(1), .CLR_VAL(8'h00)) dut1 (
        .clk_i(clk), .arst_i(arst), .clr_i(clr), .busy_o(busy1), .req_i(req), .ready_o(ready1),
        .we_i(we), .addr_i(addr), .data_i(wdata), .rvalid_o(rv1), .data_o(q1)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] val;
    } rd_t;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            clear_left;
    logic [DW-1:0] mem [DEPTH];
    rd_t           pend0[$];
    rd_t           pend1[$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outs();
        logic e0, e1;
        check1("busy0", busy0, clear_left > 0);
        check1("ready0", ready0, clear_left == 0);
        check1("busy1", busy1, clear_left > 0);
        check1("ready1", ready1, clear_left == 0);
        e0 = (pend0.size() > 0) && (pend0[0].due == cyc);
        e1 = (pend1.size() > 0) && (pend1[0].due == cyc);
        check1("rvalid0", rv0, e0);
        check1("rvalid1", rv1, e1);
        if (e0) begin
            check("data0", q0, pend0[0].val);
            void'(pend0.pop_front());
        end
        if (e1) begin
            check("data1", q1, pend1[0].val);
            void'(pend1.pop_front());
        end
    endtask

    task automatic wipe_model();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    endtask

    // Apply the current inputs to the model, clock once, then compare.
    task automatic step();
        rd_t r;
        if (clear_left == 0) begin
            if (req) begin
                if (we != '0) begin
                    for (int k = 0; k < NL; k++)
                        if (we[k]) mem[addr][k*LW +: LW] = wdata[k*LW +: LW];
                end else begin
                    r.val = mem[addr];
                    r.due = cyc + 1;
                    pend0.push_back(r);
                    r.due = cyc + 2;
                    pend1.push_back(r);
                end
            end
            if (clr) begin
                clear_left = DEPTH;
                wipe_model();
            end
        end else begin
            clear_left--;
        end
        @(posedge clk);
        #1;
        cyc++;
        check_outs();
    endtask

    task automatic reset_pulse();
        arst = 1'b1;
        #2;
        clear_left = DEPTH;
        pend0.delete();
        pend1.delete();
        wipe_model();
        check1("rst_busy0", busy0, 1'b1);
        check1("rst_ready0", ready0, 1'b0);
        check1("rst_rvalid0", rv0, 1'b0);
        check1("rst_busy1", busy1, 1'b1);
        check1("rst_ready1", ready1, 1'b0);
        check1("rst_rvalid1", rv1, 1'b0);
        check("rst_data1", q1, '0);
        #1;
        arst = 1'b0;
    endtask

    task automatic drive(input logic r, input logic [NL-1:0] w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req = r; we = w; addr = a; wdata = d;
    endtask

    initial begin
        arst = 1'b1;
        clear_left = DEPTH;
        wipe_model();
        #12;
        check1("por_busy0", busy0, 1'b1);
        check1("por_ready0", ready0, 1'b0);
        check1("por_rvalid0", rv0, 1'b0);
        check1("por_busy1", busy1, 1'b1);
        check1("por_rvalid1", rv1, 1'b0);
        check("por_data1", q1, '0);
        @(posedge clk);
        #1;
        arst = 1'b0;

        // Post-reset sweep with requests that must be ignored, then read every word.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, NL'($urandom), AW'($urandom), $urandom);
            step();
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, '0, AW'(i), '0);
            step();
        end
        drive(1'b0, '0, '0, '0);
        step(); step();

        // Partial-lane write merge.
        drive(1'b1, 4'b1111, 4'd3, 32'hDEADBEEF); step();
        drive(1'b1, 4'b0101, 4'd3, 32'h11223344); step();
        drive(1'b1, 4'b0000, 4'd3, '0);           step();
        drive(1'b0, '0, '0, '0); step(); step();

        // Back-to-back reads.
        drive(1'b1, 4'b1111, 4'd1, 32'hA1); step();
        drive(1'b1, 4'b1111, 4'd2, 32'hA2); step();
        drive(1'b1, 4'b1111, 4'd3, 32'hA3); step();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, '0, AW'(i), '0);
            step();
        end
        drive(1'b0, '0, '0, '0); step(); step();

        // Read accepted together with clr; requests during the sweep (clr again at cycle 7) are dropped.
        drive(1'b1, 4'b1111, 4'd5, 32'h55); step();
        drive(1'b1, 4'b1111, 4'd9, 32'h99); step();
        drive(1'b1, '0, 4'd5, '0);
        clr = 1'b1;
        step();
        for (int i = 0; i < DEPTH; i++) begin
            clr = (i == 7);
            drive(1'b1, 4'b1111, 4'd9, $urandom);
            step();
        end
        clr = 1'b0;
        drive(1'b1, '0, 4'd5, '0); step();
        drive(1'b1, '0, 4'd9, '0); step();
        drive(1'b0, '0, '0, '0); step(); step();

        // Reset with a read in flight, then reset at sweep cycle 10.
        drive(1'b1, 4'b1111, 4'd2, 32'hCAFEF00D); step();
        drive(1'b1, '0, 4'd2, '0); step();
        drive(1'b0, '0, '0, '0);
        reset_pulse();
        for (int i = 0; i < 10; i++) step();
        reset_pulse();
        for (int i = 0; i < DEPTH; i++) step();
        drive(1'b1, '0, 4'd2, '0); step();
        drive(1'b0, '0, '0, '0); step(); step();

        // Random traffic with occasional clear requests.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 2) ? NL'($urandom) : '0, AW'($urandom), $urandom);
            clr = ($urandom % 40) == 0;
            step();
        end
        clr = 1'b0;
        drive(1'b0, '0, '0, '0);
        for (int i = 0; i < 20; i++) step();

        n_assert++;
        assert (pend0.size() == 0 && pend1.size() == 0) else begin
            n_fail++;
            $error("FAIL drain observed=%0d/%0d expected=0/0", pend0.size(), pend1.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
